// File: rtl/i2c_target_pkg.sv
// Shared types and defaults for the I2C target responder.
package i2c_target_pkg;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h50;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the core clock and flags SCL edges plus START/STOP.
module i2c_bus_monitor (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise_c,
  output logic o_scl_fall_c,
  output logic o_start_c,
  output logic o_stop_c
);

  logic r_scl_meta;
  logic r_scl_sync;
  logic r_scl_prev;
  logic r_sda_meta;
  logic r_sda_sync;
  logic r_sda_prev;

  // Idle bus level is high, so every flop resets to 1 to avoid a false edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
    end
  end

  assign o_sda        = r_sda_sync;
  assign o_scl_rise_c = r_scl_sync & ~r_scl_prev;
  assign o_scl_fall_c = ~r_scl_sync & r_scl_prev;
  assign o_start_c    = r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign o_stop_c     = r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target with a small register file: pointer-then-data writes, sequential reads.
module i2c_target_responder
  import i2c_target_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int unsigned REG_DEPTH   = 8
) (
  input  logic                         core_clk,
  input  logic                         core_rst,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         sda_oe,
  output logic                         busy,
  output logic                         wr_strobe,
  output logic [$clog2(REG_DEPTH)-1:0] wr_addr,
  output logic [7:0]                   wr_data
);

  localparam int unsigned PW = $clog2(REG_DEPTH);

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic [7:0] w_byte;

  state_e        r_state;
  logic          r_fall_d;
  logic [3:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic [PW-1:0] r_ptr;
  logic          r_rw;
  logic          r_first;
  logic          r_phase;
  logic          r_mack;
  logic [7:0]    r_regs [REG_DEPTH];

  i2c_bus_monitor u_mon (
    .i_clk        (core_clk),
    .i_rst        (core_rst),
    .i_scl        (scl_i),
    .i_sda        (sda_i),
    .o_sda        (w_sda),
    .o_scl_rise_c (w_scl_rise),
    .o_scl_fall_c (w_scl_fall),
    .o_start_c    (w_start),
    .o_stop_c     (w_stop)
  );

  // Byte completed by the bit arriving on this SCL rise.
  assign w_byte = {r_shift, w_sda};

  // SDA only changes on r_fall_d so it is stable well before the next SCL rise.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      r_state   <= IDLE;
      r_fall_d  <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_first   <= 1'b0;
      r_phase   <= 1'b0;
      r_mack    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      for (int i = 0; i < int'(REG_DEPTH); i++) r_regs[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      r_fall_d  <= w_scl_fall;
      if (w_stop) begin
        r_state <= IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_bit_cnt <= '0;
        sda_oe    <= 1'b0;
      end else begin
        case (r_state)
          ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_phase <= 1'b0;
                if (w_byte[7:1] == TARGET_ADDR) begin
                  r_state <= ADDR_ACK;
                  r_rw    <= w_sda;
                  busy    <= 1'b1;
                end else begin
                  r_state <= IGNORE;
                end
              end
            end
          end
          // First fall starts the ACK pull-down, second fall ends the 9th period.
          ADDR_ACK: begin
            if (r_fall_d) begin
              if (!r_phase) begin
                sda_oe  <= 1'b1;
                r_phase <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                r_bit_cnt <= '0;
                if (r_rw) begin
                  r_state <= RD_BYTE;
                  r_shift <= r_regs[r_ptr][6:0];
                  sda_oe  <= ~r_regs[r_ptr][7];
                end else begin
                  r_state <= WR_BYTE;
                  r_first <= 1'b1;
                  sda_oe  <= 1'b0;
                end
              end
            end
          end
          WR_BYTE: begin
            if (w_scl_rise) begin
              r_shift   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_state <= WR_ACK;
                r_phase <= 1'b0;
                if (r_first) begin
                  r_ptr   <= w_byte[PW-1:0];
                  r_first <= 1'b0;
                end else begin
                  r_regs[r_ptr] <= w_byte;
                  wr_strobe     <= 1'b1;
                  wr_addr       <= r_ptr;
                  wr_data       <= w_byte;
                  r_ptr         <= r_ptr + PW'(1);
                end
              end
            end
          end
          WR_ACK: begin
            if (r_fall_d) begin
              if (!r_phase) begin
                sda_oe  <= 1'b1;
                r_phase <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                r_phase   <= 1'b0;
                r_bit_cnt <= '0;
                r_state   <= WR_BYTE;
              end
            end
          end
          RD_BYTE: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_ptr   <= r_ptr + PW'(1);
                r_state <= RD_ACK;
                r_phase <= 1'b0;
                r_mack  <= 1'b0;
              end
            end else if (r_fall_d) begin
              r_shift <= {r_shift[5:0], 1'b0};
              sda_oe  <= ~r_shift[6];
            end
          end
          // Release for the master's bit; an ACK reloads on the next fall.
          RD_ACK: begin
            if (r_fall_d && !r_phase) begin
              sda_oe  <= 1'b0;
              r_phase <= 1'b1;
            end else if (w_scl_rise && r_phase) begin
              if (w_sda) r_state <= IGNORE;
              else       r_mack  <= 1'b1;
            end else if (r_fall_d && r_mack) begin
              r_state   <= RD_BYTE;
              r_mack    <= 1'b0;
              r_phase   <= 1'b0;
              r_bit_cnt <= '0;
              r_shift   <= r_regs[r_ptr][6:0];
              sda_oe    <= ~r_regs[r_ptr][7];
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bus-level bench: a bit-banged I2C master against a transaction-level register model.
module tb_i2c_target_responder;

  localparam int unsigned Q   = 8;
  localparam logic [6:0]  TGT = 7'h50;

  logic       core_clk  = 1'b0;
  logic       core_rst  = 1'b1;
  logic       r_scl     = 1'b1;
  logic       r_sda_m   = 1'b1;
  logic       w_sda;
  logic       sda_oe;
  logic       busy;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  int         n_err = 0;
  int         n_chk = 0;
  logic [7:0] m_regs [8];
  int         m_ptr;
  int         exp_q [$];
  int         obs_q [$];
  int         oe_cnt;
  logic [7:0] wbuf [4];

  assign w_sda = r_sda_m & ~sda_oe;

  i2c_target_responder #(.TARGET_ADDR(TGT), .REG_DEPTH(8)) dut (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .scl_i     (r_scl),
    .sda_i     (w_sda),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 core_clk = ~core_clk;

  always @(negedge core_clk) begin
    if (wr_strobe === 1'b1) obs_q.push_back(int'(wr_addr) * 256 + int'(wr_data));
    if (sda_oe === 1'b1) oe_cnt++;
  end

  initial begin
    #950000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitq(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic bus_start();
    r_sda_m = 1'b1; r_scl = 1'b1; waitq(Q);
    r_sda_m = 1'b0; waitq(Q);
    r_scl = 1'b0; waitq(Q);
  endtask

  task automatic bus_rstart();
    r_sda_m = 1'b1; waitq(Q);
    r_scl = 1'b1; waitq(Q);
    r_sda_m = 1'b0; waitq(Q);
    r_scl = 1'b0; waitq(Q);
  endtask

  task automatic bus_stop();
    r_sda_m = 1'b0; waitq(Q);
    r_scl = 1'b1; waitq(Q);
    r_sda_m = 1'b1; waitq(Q);
  endtask

  task automatic write_bit(input logic b);
    r_sda_m = b; waitq(Q);
    r_scl = 1'b1; waitq(2 * Q);
    r_scl = 1'b0; waitq(Q);
  endtask

  task automatic read_bit(output logic b);
    r_sda_m = 1'b1; waitq(Q);
    r_scl = 1'b1; waitq(Q);
    b = w_sda; waitq(Q);
    r_scl = 1'b0; waitq(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  task automatic chk_strobes();
    chk("n_strobe", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk("strobe", 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
  endtask

  // Address, pointer byte, then n data bytes from wbuf.
  task automatic do_write(input logic [6:0] addr, input logic [7:0] ptrb, input int n);
    logic a;
    logic hit;
    hit = (addr == TGT);
    bus_start();
    send_byte({addr, 1'b0}, a);
    chk("addr_ack", 32'(a), hit ? 32'd0 : 32'd1);
    if (hit) begin
      chk("busy_wr", 32'(busy), 32'd1);
      send_byte(ptrb, a);
      chk("ptr_ack", 32'(a), 32'd0);
      m_ptr = int'(ptrb) % 8;
      for (int i = 0; i < n; i++) begin
        send_byte(wbuf[i], a);
        chk("wr_ack", 32'(a), 32'd0);
        m_regs[m_ptr] = wbuf[i];
        exp_q.push_back(m_ptr * 256 + int'(wbuf[i]));
        m_ptr = (m_ptr + 1) % 8;
      end
    end
    bus_stop();
    waitq(4);
    chk("busy_idle", 32'(busy), 32'd0);
    chk_strobes();
  endtask

  // Optional pointer set plus repeated start, then n bytes, last one NACKed.
  task automatic do_read(input logic set_ptr, input logic [7:0] ptrb, input int n);
    logic       a;
    logic [7:0] d;
    bus_start();
    if (set_ptr) begin
      send_byte({TGT, 1'b0}, a);
      chk("addr_ack", 32'(a), 32'd0);
      send_byte(ptrb, a);
      chk("ptr_ack", 32'(a), 32'd0);
      m_ptr = int'(ptrb) % 8;
      bus_rstart();
    end
    send_byte({TGT, 1'b1}, a);
    chk("raddr_ack", 32'(a), 32'd0);
    chk("busy_rd", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, (i == n - 1));
      chk("rd_data", 32'(d), 32'(m_regs[m_ptr]));
      m_ptr = (m_ptr + 1) % 8;
    end
    bus_stop();
    waitq(4);
    chk("busy_idle", 32'(busy), 32'd0);
    chk_strobes();
  endtask

  initial begin
    logic a;
    logic b;
    model_reset();
    oe_cnt = 0;
    waitq(4);
    chk("rst_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_waddr", 32'(wr_addr), 32'd0);
    chk("rst_wdata", 32'(wr_data), 32'd0);
    core_rst = 1'b0;
    waitq(4);

    wbuf[0] = 8'h3C; do_write(TGT, 8'd4, 1);
    wbuf[0] = 8'h5A; do_write(TGT, 8'd2, 1);
    do_read(1'b1, 8'd2, 2);
    do_read(1'b0, 8'd0, 1);

    oe_cnt = 0;
    wbuf[0] = 8'h02; do_write(7'h51, 8'd0, 1);
    chk("ignore_oe", 32'(oe_cnt), 32'd0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; do_write(TGT, 8'd7, 2);

    // Reset while the target drives bit 4 of a read byte.
    bus_start();
    send_byte({TGT, 1'b0}, a); chk("addr_ack", 32'(a), 32'd0);
    send_byte(8'h01, a);       chk("ptr_ack", 32'(a), 32'd0);
    m_ptr = 1;
    bus_rstart();
    send_byte({TGT, 1'b1}, a); chk("raddr_ack", 32'(a), 32'd0);
    for (int i = 7; i > 4; i--) begin
      read_bit(b);
      chk("rd_bit", 32'(b), 32'(m_regs[1][i]));
    end
    r_sda_m = 1'b1; waitq(Q);
    r_scl = 1'b1; waitq(Q);
    chk("oe_pre_rst", 32'(sda_oe), 32'(!m_regs[1][4]));
    core_rst = 1'b1;
    #1;
    chk("oe_in_rst", 32'(sda_oe), 32'd0);
    chk("busy_in_rst", 32'(busy), 32'd0);
    waitq(3);
    core_rst = 1'b0;
    model_reset();
    obs_q.delete();
    waitq(4);
    do_read(1'b1, 8'd7, 2);

    // STOP in the middle of a data byte.
    bus_start();
    send_byte({TGT, 1'b0}, a); chk("addr_ack", 32'(a), 32'd0);
    send_byte(8'h03, a);       chk("ptr_ack", 32'(a), 32'd0);
    m_ptr = 3;
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    bus_stop();
    chk("oe_stop", 32'(sda_oe), 32'd0);
    waitq(2);
    chk("busy_stop", 32'(busy), 32'd0);
    chk_strobes();
    do_read(1'b0, 8'd0, 1);

    for (int t = 0; t < 14; t++) begin
      int kind;
      int n;
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(1, 3));
      if (kind <= 1) begin
        for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
        if (kind == 1) begin
          oe_cnt = 0;
          do_write(7'h51 + 7'($urandom_range(0, 40)), 8'($urandom), n);
          chk("ignore_oe", 32'(oe_cnt), 32'd0);
        end else begin
          do_write(TGT, 8'($urandom), n);
        end
      end else begin
        do_read(kind == 2, 8'($urandom), n);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_target_responder.md
I2C_TARGET_RESPONDER -- requirements
Module: i2c_target_responder

Interface
REQ-001 SHALL have parameter TARGET_ADDR, 7'h50, 7-bit address the block answers to.
REQ-002 SHALL have parameter REG_DEPTH, 8, number of 8-bit internal registers (power of two, 2..16).
REQ-003 SHALL have port core_clk  input  1  sole clock; SCL/SDA are oversampled on its rising edge.
REQ-004 SHALL have port core_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port scl_i  input  1  bus SCL level (resolved wire).
REQ-006 SHALL have port sda_i  input  1  bus SDA level (resolved wire).
REQ-007 SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release (open-drain enable).
REQ-008 SHALL have port busy  output  1  high from an addressed START until STOP.
REQ-009 SHALL have port wr_strobe  output  1  one-cycle pulse per register written.
REQ-010 SHALL have port wr_addr  output  $clog2(REG_DEPTH)  index written on wr_strobe.
REQ-011 SHALL have port wr_data  output  8  byte written on wr_strobe.

Function
REQ-012 SHALL pass scl_i/sda_i through 2-flop synchronizers; all edge detection uses synchronized values.
REQ-013 SHALL detect START as synced SDA 1->0 while synced SCL=1, and STOP as SDA 0->1 while SCL=1.
REQ-014 SHALL sample SDA on each detected SCL rising edge and update sda_oe only on the cycle after a detected SCL falling edge.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-016 SHALL go from any state to ADDR on START (repeated start included), with bit counter cleared.
REQ-017 SHALL go from any state to IDLE on STOP, with sda_oe=0 and busy=0 on the next cycle.
REQ-018 SHALL, in ADDR after 8 bits MSB-first, enter ADDR_ACK on match of bits[7:1] with TARGET_ADDR, else IGNORE (sda_oe held 0 until STOP/START).
REQ-019 SHALL drive sda_oe=1 during the 9th SCL period of an ACK (from SCL fall after bit 8 to SCL fall after bit 9).
REQ-020 SHALL, after ADDR_ACK, enter WR_BYTE if R/W=0, else RD_BYTE with sda_oe=~reg[ptr][7] from the ACK-ending SCL fall.
REQ-021 SHALL treat the first byte of a write transfer as the pointer: ptr <= byte[$clog2(REG_DEPTH)-1:0], no wr_strobe.
REQ-022 SHALL, for subsequent write bytes, write reg[ptr], pulse wr_strobe with wr_addr=ptr and wr_data=byte on the cycle of the 8th SCL rise, then ptr <= ptr+1 modulo REG_DEPTH.
REQ-023 SHALL ACK every write byte (WR_ACK), then return to WR_BYTE.
REQ-024 SHALL, in RD_BYTE, shift reg[ptr] MSB-first (sda_oe = ~bit) and increment ptr modulo REG_DEPTH after bit 0.
REQ-025 SHALL, in RD_ACK, release SDA and sample the master bit: 0 (ACK) -> RD_BYTE with next byte; 1 (NACK) -> IGNORE.
REQ-026 SHALL retain ptr across STOP and repeated START (pointer-set write then repeated-start read works).
REQ-027 SHALL never drive SCL (no clock stretching).

Reset
REQ-028 SHALL on core_rst=1 immediately set state=IDLE, sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, ptr=0, all registers 8'h00, synchronizer flops to 1.
REQ-029 SHALL abandon any transfer when reset asserts mid-byte; after release, wait for a fresh START.

Structure
REQ-030 SHALL place the state enum typedef and the default TARGET_ADDR constant in package i2c_target_pkg.
REQ-031 SHALL implement synchronizers, SCL edge and START/STOP detection in sub-module i2c_bus_monitor.

Verification
REQ-032 SHALL cover: START, 0xA0, 0x02, 0x5A, STOP -> ACK on all three bytes; one wr_strobe with wr_addr=2, wr_data=0x5A; busy falls after STOP.
REQ-033 SHALL cover: START, 0xA0, 0x02, Sr, 0xA1, read 2 bytes (ACK then NACK), STOP, with reg2=0x5A, reg3=0x00 -> bus reads 0x5A, 0x00; ptr=4 afterwards.
REQ-034 SHALL cover: START, 0xA2 (address 0x51) -> no ACK (SDA high in bit 9), sda_oe=0 throughout, no wr_strobe.
REQ-035 SHALL cover: pointer 7, write 0x11, 0x22 -> wr_strobe at addr 7 then 0 (wrap).
REQ-036 SHALL cover: core_rst pulse during bit 4 of a data byte -> sda_oe=0 within the same cycle, regs cleared, next transfer ACKed normally.
REQ-037 SHALL cover: STOP injected mid write-byte -> IDLE, no wr_strobe, sda_oe=0 next cycle.
